// File: rtl/program_memory_arbiter.sv
// program_memory_arbiter
// Shares the single synchronous program-ROM read port between the CPU fetch
// requester and the debug/trace requester. Fetch has fixed priority, with a
// starvation counter that forces a debug grant after STARVE_LIMIT consecutive
// denied debug cycles. Byte addresses in the text segment are turned into ROM
// word indices. One grant per cycle, read data returned one cycle later.
// Optional feature: define PM_ARB_RANGE_CHECK_EN to add the registered 'fault'
// output and suppress ROM reads for misaligned or out-of-segment addresses.

module program_memory_arbiter #(
    parameter int                 MEMORY_DEPTH = 32,
    parameter int                 DATA_WIDTH   = 32,
    parameter logic [31:0]        TEXT_BASE    = 32'h0040_0000,
    parameter int                 STARVE_LIMIT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            fetch_req,
    input  logic [DATA_WIDTH-1:0]           fetch_addr,
    output logic                            fetch_gnt,
    output logic                            fetch_valid,
    output logic [DATA_WIDTH-1:0]           fetch_data,
    input  logic                            dbg_req,
    input  logic [DATA_WIDTH-1:0]           dbg_addr,
    output logic                            dbg_gnt,
    output logic                            dbg_valid,
    output logic [DATA_WIDTH-1:0]           dbg_data,
    output logic                            mem_rd_en,
    output logic [$clog2(MEMORY_DEPTH)-1:0] mem_addr,
`ifdef PM_ARB_RANGE_CHECK_EN
    output logic                            fault,
`endif
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int              AW    = $clog2(MEMORY_DEPTH);
    localparam logic [3:0]      LIMIT = 4'(STARVE_LIMIT);
    localparam logic [DATA_WIDTH-1:0] BASE = DATA_WIDTH'(TEXT_BASE);

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  dbg_valid_q, dbg_valid_d;
    logic [DATA_WIDTH-1:0] fetch_hold_q, fetch_hold_d;
    logic [DATA_WIDTH-1:0] dbg_hold_q, dbg_hold_d;
    logic                  fault_q, fault_d;

    logic                  starve_hit;
    logic                  any_gnt;
    logic                  addr_bad;
    logic [DATA_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] offset;
    logic [AW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  unused_bits;

`ifdef PM_ARB_RANGE_CHECK_EN
    assign unused_bits = ^offset[1:0];
    assign fault       = fault_q;
`else
    assign unused_bits = ^{offset[DATA_WIDTH-1:AW+2], offset[1:0]};
`endif

    // Arbitration, address translation, starvation tracking and output data muxing.
    always_comb begin
        starve_hit   = dbg_req && (starve_cnt_q == LIMIT);
        fetch_gnt    = fetch_req && !starve_hit;
        dbg_gnt      = dbg_req && !fetch_gnt;
        any_gnt      = fetch_gnt || dbg_gnt;

        sel_addr     = dbg_gnt ? dbg_addr : fetch_addr;
        offset       = sel_addr - BASE;
        word_idx     = offset[AW+1:2];

`ifdef PM_ARB_RANGE_CHECK_EN
        addr_bad     = (sel_addr[1:0] != 2'b00) || (sel_addr < BASE) ||
                       (offset[DATA_WIDTH-1:2] >= (DATA_WIDTH-2)'(MEMORY_DEPTH));
`else
        addr_bad     = 1'b0;
`endif

        mem_rd_en    = any_gnt && !addr_bad;
        mem_addr     = mem_rd_en ? word_idx : '0;

        starve_cnt_d = starve_cnt_q;
        if (!dbg_req || dbg_gnt) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        fetch_valid_d = fetch_gnt;
        dbg_valid_d   = dbg_gnt;
        fault_d       = any_gnt && addr_bad;

        read_data     = fault_q ? '0 : mem_rdata;
        fetch_valid   = fetch_valid_q;
        dbg_valid     = dbg_valid_q;
        fetch_data    = fetch_valid_q ? read_data : fetch_hold_q;
        dbg_data      = dbg_valid_q ? read_data : dbg_hold_q;

        fetch_hold_d  = fetch_data;
        dbg_hold_d    = dbg_data;
    end

    // Owner/valid tracking, held output data and starvation count; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q  <= '0;
            fetch_valid_q <= 1'b0;
            dbg_valid_q   <= 1'b0;
            fetch_hold_q  <= '0;
            dbg_hold_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            fetch_valid_q <= fetch_valid_d;
            dbg_valid_q   <= dbg_valid_d;
            fetch_hold_q  <= fetch_hold_d;
            dbg_hold_q    <= dbg_hold_d;
            fault_q       <= fault_d;
        end
    end

endmodule

// File: tb/tb_program_memory_arbiter.sv
// tb_program_memory_arbiter
// Self-checking bench for program_memory_arbiter with a synchronous ROM model.
// Builds with or without PM_ARB_RANGE_CHECK_EN.

module tb_program_memory_arbiter;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        dbg_req;
    logic [31:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_valid;
    logic [31:0] dbg_data;
    logic        mem_rd_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
`ifdef PM_ARB_RANGE_CHECK_EN
    logic        fault;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    program_memory_arbiter #(
        .MEMORY_DEPTH(32),
        .DATA_WIDTH(32),
        .TEXT_BASE(BASE),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fetch_req(fetch_req),
        .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_data(fetch_data),
        .dbg_req(dbg_req),
        .dbg_addr(dbg_addr),
        .dbg_gnt(dbg_gnt),
        .dbg_valid(dbg_valid),
        .dbg_data(dbg_data),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
`ifdef PM_ARB_RANGE_CHECK_EN
        .fault(fault),
`endif
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [4:0] idx);
        return 32'h1000_0000 + ({27'd0, idx} * 32'h0101_0011);
    endfunction

    // Synchronous ROM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= rom_word(mem_addr);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input logic f_req, input logic [31:0] f_addr,
                                  input logic d_req, input logic [31:0] d_addr);
        fetch_req  = f_req;
        fetch_addr = f_addr;
        dbg_req    = d_req;
        dbg_addr   = d_addr;
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        exp_fg;
        logic        exp_dg;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        prev_fg, prev_dg;
        logic [4:0]  prev_idx;
        logic [31:0] f_hold, d_hold;
        logic        exp_dbg_win;

        vecs[0]  = '{1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 32'h0040_0000,  1'b0, 32'h0,          1'b1, 1'b0, 5'd0};
        vecs[2]  = '{1'b0, 32'h0,          1'b1, 32'h0040_0010,  1'b0, 1'b1, 5'd4};
        vecs[3]  = '{1'b1, 32'h0040_007C,  1'b0, 32'h0,          1'b1, 1'b0, 5'd31};
        vecs[4]  = '{1'b1, 32'h0040_0008,  1'b1, 32'h0040_000C,  1'b1, 1'b0, 5'd2};
        vecs[5]  = '{1'b1, 32'h0040_0008,  1'b1, 32'h0040_000C,  1'b1, 1'b0, 5'd2};
        vecs[6]  = '{1'b1, 32'h0040_0014,  1'b0, 32'h0,          1'b1, 1'b0, 5'd5};
        vecs[7]  = '{1'b1, 32'h0040_0018,  1'b1, 32'h0040_0020,  1'b1, 1'b0, 5'd6};
        vecs[8]  = '{1'b0, 32'h0,          1'b1, 32'h0040_0004,  1'b0, 1'b1, 5'd1};
        vecs[9]  = '{1'b1, 32'h0040_001C,  1'b1, 32'h0040_0024,  1'b1, 1'b0, 5'd7};
        vecs[10] = '{1'b0, 32'h0,          1'b0, 32'h0,          1'b0, 1'b0, 5'd0};

        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check_output("rst_dbg_valid",   {31'd0, dbg_valid},   32'd0);
        check_output("rst_fetch_data",  fetch_data,           32'd0);
        check_output("rst_dbg_data",    dbg_data,             32'd0);
`ifdef PM_ARB_RANGE_CHECK_EN
        check_output("rst_fault",       {31'd0, fault},       32'd0);
`endif
        reset = 1'b1;

        $display("[TB] idle after reset");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output("idle_rd_en",       {31'd0, mem_rd_en},   32'd0);
            check_output("idle_mem_addr",    {27'd0, mem_addr},    32'd0);
            check_output("idle_fetch_valid", {31'd0, fetch_valid}, 32'd0);
            check_output("idle_dbg_valid",   {31'd0, dbg_valid},   32'd0);
            check_output("idle_data",        fetch_data | dbg_data, 32'd0);
        end

        $display("[TB] vector table");
        prev_fg  = 1'b0;
        prev_dg  = 1'b0;
        prev_idx = 5'd0;
        f_hold   = 32'd0;
        d_hold   = 32'd0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (prev_fg) f_hold = rom_word(prev_idx);
            if (prev_dg) d_hold = rom_word(prev_idx);
            check_output($sformatf("vec%0d_fetch_valid", i), {31'd0, fetch_valid}, {31'd0, prev_fg});
            check_output($sformatf("vec%0d_dbg_valid", i),   {31'd0, dbg_valid},   {31'd0, prev_dg});
            check_output($sformatf("vec%0d_fetch_data", i),  fetch_data, f_hold);
            check_output($sformatf("vec%0d_dbg_data", i),    dbg_data,   d_hold);
            apply_stimulus(vecs[i].f_req, vecs[i].f_addr, vecs[i].d_req, vecs[i].d_addr);
            #1;
            check_output($sformatf("vec%0d_fetch_gnt", i), {31'd0, fetch_gnt}, {31'd0, vecs[i].exp_fg});
            check_output($sformatf("vec%0d_dbg_gnt", i),   {31'd0, dbg_gnt},   {31'd0, vecs[i].exp_dg});
            check_output($sformatf("vec%0d_rd_en", i),     {31'd0, mem_rd_en}, {31'd0, vecs[i].exp_fg | vecs[i].exp_dg});
            check_output($sformatf("vec%0d_mem_addr", i),  {27'd0, mem_addr},  {27'd0, vecs[i].exp_idx});
            prev_fg  = vecs[i].exp_fg;
            prev_dg  = vecs[i].exp_dg;
            prev_idx = vecs[i].exp_idx;
        end

        $display("[TB] back-to-back fetch");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_output("b2b_fetch_valid", {31'd0, fetch_valid}, 32'd1);
                check_output("b2b_fetch_data",  fetch_data, rom_word(5'(k - 1)));
            end
            if (k < 3) begin
                apply_stimulus(1'b1, BASE + 32'(4 * k), 1'b0, 32'h0);
                #1;
                check_output("b2b_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
                check_output("b2b_mem_addr",  {27'd0, mem_addr},  32'(k));
            end else begin
                apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
            end
        end
        @(negedge clk);
        check_output("b2b_valid_drop", {31'd0, fetch_valid}, 32'd0);

        $display("[TB] starvation guard");
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c > 0) begin
                exp_dbg_win = ((c - 1) % 5) == 4;
                check_output("starve_dbg_valid", {31'd0, dbg_valid}, {31'd0, exp_dbg_win});
                if (exp_dbg_win) check_output("starve_dbg_data", dbg_data, rom_word(5'd16));
            end
            if (c < 15) begin
                apply_stimulus(1'b1, BASE, 1'b1, BASE + 32'h40);
                exp_dbg_win = (c % 5) == 4;
                #1;
                check_output("starve_dbg_gnt",   {31'd0, dbg_gnt},   {31'd0, exp_dbg_win});
                check_output("starve_fetch_gnt", {31'd0, fetch_gnt}, {31'd0, !exp_dbg_win});
                check_output("starve_mem_addr",  {27'd0, mem_addr},  exp_dbg_win ? 32'd16 : 32'd0);
            end else begin
                apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
            end
        end

        $display("[TB] reset during in-flight debug read");
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 1'b1, BASE + 32'h8);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check_output("rstfly_dbg_valid_now", {31'd0, dbg_valid}, 32'd0);
        check_output("rstfly_dbg_data_now",  dbg_data,           32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_output("rstfly_dbg_valid_after", {31'd0, dbg_valid}, 32'd0);
            check_output("rstfly_dbg_data_after",  dbg_data,           32'd0);
        end

        // Build up the starvation count, reset, then confirm it restarted from zero.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            apply_stimulus(1'b1, BASE, 1'b1, BASE + 32'h8);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        check_output("rstcnt_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            apply_stimulus(1'b1, BASE, 1'b1, BASE + 32'h8);
            #1;
            check_output("rstcnt_dbg_gnt", {31'd0, dbg_gnt}, (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] misaligned and out-of-range fetch");
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_output("range_fetch_valid", {31'd0, fetch_valid}, 32'd1);
`ifdef PM_ARB_RANGE_CHECK_EN
                check_output("range_fetch_data", fetch_data, 32'd0);
                check_output("range_fault", {31'd0, fault}, 32'd1);
`else
                check_output("range_fetch_data", fetch_data, rom_word(5'd0));
`endif
            end
            if (k < 2) begin
                apply_stimulus(1'b1, (k == 0) ? 32'h0040_0002 : 32'h0040_0080, 1'b0, 32'h0);
                #1;
                check_output("range_fetch_gnt", {31'd0, fetch_gnt}, 32'd1);
                check_output("range_mem_addr",  {27'd0, mem_addr},  32'd0);
`ifdef PM_ARB_RANGE_CHECK_EN
                check_output("range_rd_en", {31'd0, mem_rd_en}, 32'd0);
`else
                check_output("range_rd_en", {31'd0, mem_rd_en}, 32'd1);
`endif
            end else begin
                apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
            end
        end
        @(negedge clk);
        check_output("range_valid_drop", {31'd0, fetch_valid}, 32'd0);
`ifdef PM_ARB_RANGE_CHECK_EN
        check_output("range_fault_drop", {31'd0, fault}, 32'd0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
